// File: rtl/lane_dly_tap_sequencer.sv
// Delay-line tap sequencer: turns tap move/load requests into spaced LOAD/MOVE pulses and tracks RX/TX DQS taps.
// Define LANE_DLY_SEQ_PAUSE_EN to wrap each command in an HS_IO_CLK_PAUSE window (lead/trail phases).
module lane_dly_tap_sequencer #(
  parameter int         PAUSE_LEAD  = 2,
  parameter int         PAUSE_TRAIL = 2,
  parameter logic [7:0] MAX_TAP     = 8'd255,
  parameter logic [7:0] LOAD_TAP    = 8'd1
) (
  input  logic       FAB_CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_SEL,
  input  logic       REQ_LOAD,
  input  logic       REQ_DIR,
  input  logic [7:0] REQ_COUNT,
  output logic       DELAY_LINE_SEL,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       HS_IO_CLK_PAUSE,
  input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
  output logic       DONE,
  output logic       DONE_ERR,
  output logic [7:0] RX_TAP,
  output logic [7:0] TX_TAP
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_TRAIL = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [7:0] LEAD_INIT  = 8'(PAUSE_LEAD - 1);
  localparam logic [7:0] TRAIL_INIT = 8'(PAUSE_TRAIL - 1);

`ifdef LANE_DLY_SEQ_PAUSE_EN
  localparam state_t S_POST = S_TRAIL;
`else
  localparam state_t S_POST = S_FIN;
`endif

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       dir_q, dir_d;
  logic       load_q, load_d;
  logic       abort_q, abort_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] rx_tap_q, rx_tap_d;
  logic [7:0] tx_tap_q, tx_tap_d;
  logic       ready_q, ready_d;
  logic       move_q, move_d;
  logic       load_pulse_q, load_pulse_d;
  logic       pause_q, pause_d;
  logic       done_q, done_d;
  logic       done_err_q, done_err_d;

  logic [7:0] cur_tap;
  logic [7:0] step_tap;
  logic       oor;

  // A move is blocked when the next step would leave 0..MAX_TAP.
  function automatic logic blocked(input logic [7:0] tap, input logic dir);
    return dir ? (tap >= MAX_TAP) : (tap == 8'd0);
  endfunction

  assign cur_tap  = sel_q ? tx_tap_q : rx_tap_q;
  assign step_tap = dir_q ? (cur_tap + 8'd1) : (cur_tap - 8'd1);
  assign oor      = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

`ifndef LANE_DLY_SEQ_PAUSE_EN
  logic [7:0] req_tap;
  assign req_tap = REQ_SEL ? tx_tap_q : rx_tap_q;
`endif

  // Next-state, tracker and output computation; outputs derive from the next state so they register cleanly.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    load_d   = load_q;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    rx_tap_d = rx_tap_q;
    tx_tap_d = tx_tap_q;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          sel_d   = REQ_SEL;
          dir_d   = REQ_DIR;
          load_d  = REQ_LOAD;
          cnt_d   = REQ_COUNT;
          abort_d = 1'b0;
          tmr_d   = LEAD_INIT;
          if (!REQ_LOAD && (REQ_COUNT == 8'd0)) begin
            state_d = S_FIN;
          end else begin
`ifdef LANE_DLY_SEQ_PAUSE_EN
            state_d = S_LEAD;
`else
            if (!REQ_LOAD && blocked(req_tap, REQ_DIR)) begin
              abort_d = 1'b1;
              state_d = S_FIN;
            end else begin
              state_d = S_PULSE;
            end
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD: begin
        if (tmr_q == 8'd0) begin
          if (!load_q && blocked(cur_tap, dir_q)) begin
            abort_d = 1'b1;
            tmr_d   = TRAIL_INIT;
            state_d = S_POST;
          end else begin
            state_d = S_PULSE;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_PULSE: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        tmr_d = TRAIL_INIT;
        if (oor) begin
          abort_d = 1'b1;
          state_d = S_POST;
        end else if (load_q) begin
          if (sel_q) begin
            tx_tap_d = LOAD_TAP;
          end else begin
            rx_tap_d = LOAD_TAP;
          end
          state_d = S_POST;
        end else begin
          if (sel_q) begin
            tx_tap_d = step_tap;
          end else begin
            rx_tap_d = step_tap;
          end
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_POST;
          end else if (blocked(step_tap, dir_q)) begin
            abort_d = 1'b1;
            state_d = S_POST;
          end else begin
            state_d = S_PULSE;
          end
        end
      end
      S_TRAIL: begin
        if (tmr_q == 8'd0) begin
          state_d = S_FIN;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d      = (state_d == S_IDLE);
    move_d       = (state_d == S_PULSE) && !load_d;
    load_pulse_d = (state_d == S_PULSE) && load_d;
`ifdef LANE_DLY_SEQ_PAUSE_EN
    pause_d      = (state_d == S_LEAD) || (state_d == S_PULSE) ||
                   (state_d == S_GAP)  || (state_d == S_TRAIL);
`else
    pause_d      = 1'b0;
`endif
    done_d       = (state_d == S_FIN);
    done_err_d   = (state_d == S_FIN) && abort_d;
  end

  // All state, trackers and outputs; async reset returns everything to idle values.
  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      dir_q        <= 1'b0;
      load_q       <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= 8'd0;
      tmr_q        <= 8'd0;
      rx_tap_q     <= LOAD_TAP;
      tx_tap_q     <= LOAD_TAP;
      ready_q      <= 1'b1;
      move_q       <= 1'b0;
      load_pulse_q <= 1'b0;
      pause_q      <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      load_q       <= load_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      rx_tap_q     <= rx_tap_d;
      tx_tap_q     <= tx_tap_d;
      ready_q      <= ready_d;
      move_q       <= move_d;
      load_pulse_q <= load_pulse_d;
      pause_q      <= pause_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
    end
  end

  assign REQ_READY            = ready_q;
  assign DELAY_LINE_SEL       = sel_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = load_pulse_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign HS_IO_CLK_PAUSE      = pause_q;
  assign DONE                 = done_q;
  assign DONE_ERR             = done_err_q;
  assign RX_TAP               = rx_tap_q;
  assign TX_TAP               = tx_tap_q;

endmodule
